stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_op  input  2  00 PUSH, 01 POP, 10 PEEK, 11 MOVE.
REQ-007 cmd_sel  input  1  target stack; for MOVE, the source (destination = ~cmd_sel).
REQ-008 cmd_data  input  8  byte for PUSH.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed.
REQ-011 rsp_data  output  8  result byte.
REQ-012 rsp_err  output  1  command rejected (full/empty).
REQ-013 stack_select  output  1  selects stack 0/1; shared by both stack instances.
REQ-014 push, pop  output  1 each  strobes to the selected stack.
REQ-015 st_data  output  8  byte to stack data_in.
REQ-016 st_q  input  8  OR of both stacks' data_out; an unselected stack drives 0.
REQ-017 st_empty, st_full  input  2 each  bit i = stack i empty/full flag.
REQ-018 err_count  output  8  saturating count of rejected commands.

Function
REQ-019 SHALL implement FSM states IDLE, SEL, EXEC, MPUSH, RESP.
REQ-020 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch op/sel/data, register stack_select<=cmd_sel, go to SEL; cmd_ready=0 in all other states.
REQ-021 SEL: one wait cycle, push=pop=0, so the stack's registered select qualifier makes st_q valid in EXEC.
REQ-022 EXEC PUSH: if st_full[sel]=0, assert push for exactly one cycle with st_data=latched data and rsp_data=latched data; else error.
REQ-023 EXEC POP: if st_empty[sel]=0, capture st_q into rsp_data and assert pop for one cycle; else error.
REQ-024 EXEC PEEK: if st_empty[sel]=0, capture st_q into rsp_data with no strobe; else error.
REQ-025 EXEC MOVE: if st_empty[sel]=0 and st_full[~sel]=0, capture st_q, assert pop for one cycle, register stack_select<=~sel, go to MPUSH; else error.
REQ-026 MPUSH: assert push for one cycle with st_data=captured byte to stack ~sel; rsp_data=captured byte; go to RESP.
REQ-027 Error: no push/pop issued; rsp_err=1, rsp_data=0x00; err_count increments, saturating at 0xFF; go to RESP.
REQ-028 All non-MOVE EXEC outcomes SHALL go to RESP.
REQ-029 RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready=1; on rsp_ready go to IDLE and drop rsp_valid.
REQ-030 Latency, accept edge = cycle 0: rsp_valid first high in cycle 3 (PUSH/POP/PEEK) or cycle 4 (MOVE).
REQ-031 push and pop SHALL never be high in the same cycle; at most one strobe per command, except MOVE (one pop, then one push).
REQ-032 push/pop SHALL be decoded from state plus registered fields and the registered stack flags only; no combinational path from cmd_* or rsp_ready to push/pop.
REQ-033 stack_select SHALL hold its last value in IDLE and RESP.
REQ-034 Back-to-back: a new command SHALL be accepted no earlier than the cycle after the RESP handshake.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE.
REQ-036 rst_n=0 SHALL force stack_select=0, push=0, pop=0, st_data=0, rsp_valid=0, rsp_err=0, rsp_data=0, err_count=0; cmd_ready=1 after release.
REQ-037 Reset mid-command (including between MOVE pop and push) SHALL abandon the command with no further strobes.

Verification
REQ-038 Push 0xA5 to stack 0 from empty -> push high one cycle in cycle 2, st_data=0xA5; rsp_valid in cycle 3, rsp_data=0xA5, rsp_err=0.
REQ-039 PEEK then POP stack 0 holding 0xA5 -> both return 0xA5; only POP pulses pop; afterwards st_empty[0]=1.
REQ-040 POP on empty stack 1 -> no strobe, rsp_err=1, rsp_data=0x00, err_count 0->1.
REQ-041 Stack 0 top 0x3C, MOVE sel=0 -> pop on stack 0 in cycle 2, push 0x3C on stack 1 in cycle 3, rsp_data=0x3C in cycle 4; MOVE to a full destination -> rsp_err=1, no strobes.
REQ-042 Hold rsp_ready=0 five cycles -> rsp_valid/rsp_data stable, cmd_ready=0; a cmd_valid presented meanwhile is not accepted.
REQ-043 Assert rst_n=0 in MPUSH -> no push, all outputs at reset values; 256 errors -> err_count=0xFF.

Source files
------------

// File: rtl/stack_ctrl.sv
// Command controller for a pair of hardware stacks: accepts PUSH/POP/PEEK/MOVE
// commands, sequences the stack strobes and returns one response per command.
module stack_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_sel,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       stack_select,
  output logic       push,
  output logic       pop,
  output logic [7:0] st_data,
  input  logic [7:0] st_q,
  input  logic [1:0] st_empty,
  input  logic [1:0] st_full,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    EXEC  = 3'd2,
    MPUSH = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_MOVE = 2'b11;

  state_t     state;
  state_t     state_next;
  logic [1:0] op_q;
  logic       sel_q;
  logic [7:0] data_q;
  logic       exec_ok;
  logic       accept;

  assign accept = cmd_valid && cmd_ready;

  // Whether the latched command can proceed, judged on the stacks' own flags.
  always_comb begin
    exec_ok = 1'b0;
    case (op_q)
      OP_PUSH: exec_ok = !st_full[sel_q];
      OP_POP:  exec_ok = !st_empty[sel_q];
      OP_PEEK: exec_ok = !st_empty[sel_q];
      OP_MOVE: exec_ok = !st_empty[sel_q] && !st_full[~sel_q];
      default: exec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SEL;
      SEL:     state_next = EXEC;
      EXEC:    state_next = (op_q == OP_MOVE && exec_ok) ? MPUSH : RESP;
      MPUSH:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes depend only on state, latched fields and stack flags.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    st_data   = 8'h00;
    case (state)
      IDLE: cmd_ready = 1'b1;
      EXEC: begin
        if (exec_ok) begin
          if (op_q == OP_PUSH) begin
            push    = 1'b1;
            st_data = data_q;
          end
          if (op_q == OP_POP || op_q == OP_MOVE) pop = 1'b1;
        end
      end
      MPUSH: begin
        push    = 1'b1;
        st_data = rsp_data;
      end
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // MOVE parks the popped byte in rsp_data so MPUSH can replay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 2'b00;
      sel_q        <= 1'b0;
      data_q       <= 8'h00;
      stack_select <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_err      <= 1'b0;
      err_count    <= 8'h00;
    end else begin
      if (state == IDLE && accept) begin
        op_q         <= cmd_op;
        sel_q        <= cmd_sel;
        data_q       <= cmd_data;
        stack_select <= cmd_sel;
      end
      if (state == EXEC) begin
        if (exec_ok) begin
          rsp_err  <= 1'b0;
          rsp_data <= (op_q == OP_PUSH) ? data_q : st_q;
          if (op_q == OP_MOVE) stack_select <= ~sel_q;
        end else begin
          rsp_err  <= 1'b1;
          rsp_data <= 8'h00;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl: two behavioural stacks react to the DUT
// strobes, and a queue-based model predicts every response.
module tb_stack_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_sel = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       stack_select;
  logic       push;
  logic       pop;
  logic [7:0] st_data;
  logic [7:0] st_q;
  logic [1:0] st_empty;
  logic [1:0] st_full;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  stack_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .stack_select(stack_select), .push(push), .pop(pop),
    .st_data(st_data), .st_q(st_q), .st_empty(st_empty), .st_full(st_full),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Stack environment: registered select qualifier, unselected stack drives 0.
  logic [7:0] mem [2][DEPTH];
  int         cnt [2] = '{0, 0};
  logic       sel_reg [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      sel_reg[i] <= (stack_select == i[0]);
      if (stack_select == i[0]) begin
        if (push && cnt[i] < DEPTH) begin
          mem[i][cnt[i]] <= st_data;
          cnt[i] <= cnt[i] + 1;
        end else if (pop && cnt[i] > 0) begin
          cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  always_comb begin
    st_q     = 8'h00;
    st_empty = 2'b00;
    st_full  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sel_reg[i] && cnt[i] > 0) st_q = st_q | mem[i][cnt[i]-1];
      st_empty[i] = (cnt[i] == 0);
      st_full[i]  = (cnt[i] == DEPTH);
    end
  end

  logic [7:0] ref_stk [2][$];
  int         exp_errs = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic sel, input logic [7:0] data, input int hold);
    logic       ok;
    logic [7:0] exp_data;
    int         exp_lat, exp_push_n, exp_pop_n, exp_push_cyc;
    logic       exp_push_sel, exp_sel_after;
    int         push_n, pop_n, push_cyc, pop_cyc, got_lat;
    logic       push_sel, pop_sel, both;
    logic [7:0] push_val;

    ok = 1'b0;
    exp_data = 8'h00;
    case (op)
      2'b00: begin ok = ref_stk[sel].size() < DEPTH; exp_data = data; end
      2'b01, 2'b10: begin
        ok = ref_stk[sel].size() > 0;
        if (ok) exp_data = ref_stk[sel][$];
      end
      default: begin
        ok = ref_stk[sel].size() > 0 && ref_stk[!sel].size() < DEPTH;
        if (ok) exp_data = ref_stk[sel][$];
      end
    endcase
    if (!ok) begin
      exp_data = 8'h00;
      if (exp_errs < 255) exp_errs++;
    end
    exp_lat = (ok && op == 2'b11) ? 4 : 3;
    exp_push_n = (ok && (op == 2'b00 || op == 2'b11)) ? 1 : 0;
    exp_pop_n = (ok && (op == 2'b01 || op == 2'b11)) ? 1 : 0;
    exp_push_cyc = (op == 2'b11) ? 3 : 2;
    exp_push_sel = (op == 2'b11) ? !sel : sel;
    exp_sel_after = (ok && op == 2'b11) ? !sel : sel;
    if (ok) begin
      case (op)
        2'b00: ref_stk[sel].push_back(data);
        2'b01: void'(ref_stk[sel].pop_back());
        2'b11: ref_stk[!sel].push_back(ref_stk[sel].pop_back());
        default: ;
      endcase
    end

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_sel = sel;
    cmd_data = data;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data = 8'($urandom);

    push_n = 0; pop_n = 0; push_cyc = 0; pop_cyc = 0; got_lat = 0;
    push_sel = 1'b0; pop_sel = 1'b0; both = 1'b0; push_val = 8'h00;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (push) begin push_n++; push_cyc = cyc; push_val = st_data; push_sel = stack_select; end
      if (pop) begin pop_n++; pop_cyc = cyc; pop_sel = stack_select; end
      if (push && pop) both = 1'b1;
      if (rsp_valid) begin got_lat = cyc; break; end
    end

    checkOutput("latency", 32'(got_lat), 32'(exp_lat));
    checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
    checkOutput("rsp_err", 32'(rsp_err), 32'(!ok));
    checkOutput("err_count", 32'(err_count), 32'(exp_errs));
    checkOutput("push_count", 32'(push_n), 32'(exp_push_n));
    checkOutput("pop_count", 32'(pop_n), 32'(exp_pop_n));
    checkOutput("push_pop_overlap", 32'(both), 0);
    if (exp_push_n == 1) begin
      checkOutput("push_cycle", 32'(push_cyc), 32'(exp_push_cyc));
      checkOutput("push_data", 32'(push_val), 32'(exp_data));
      checkOutput("push_select", 32'(push_sel), 32'(exp_push_sel));
    end
    if (exp_pop_n == 1) begin
      checkOutput("pop_cycle", 32'(pop_cyc), 2);
      checkOutput("pop_select", 32'(pop_sel), 32'(sel));
    end

    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_op = 2'($urandom);
      cmd_sel = 1'($urandom);
      @(negedge clk);
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 1);
      checkOutput("hold_rsp_data", 32'(rsp_data), 32'(exp_data));
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 0);
      checkOutput("hold_strobes", 32'({push, pop}), 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", 32'(rsp_valid), 0);
    checkOutput("cmd_ready_back", 32'(cmd_ready), 1);
    checkOutput("select_held", 32'(stack_select), 32'(exp_sel_after));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_push_pop"}, 32'({push, pop}), 0);
    checkOutput({tag, "_select"}, 32'(stack_select), 0);
    checkOutput({tag, "_st_data"}, 32'(st_data), 0);
    checkOutput({tag, "_rsp"}, 32'({rsp_valid, rsp_err, rsp_data}), 0);
    checkOutput({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  initial begin
    $display("[TB] stack_ctrl bench starting");
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(cmd_ready), 1);

    // Directed scenarios first, from empty stacks.
    applyStimulus(2'b00, 1'b0, 8'hA5, 0);
    applyStimulus(2'b10, 1'b0, 8'h00, 0);
    applyStimulus(2'b01, 1'b0, 8'h00, 0);
    checkOutput("stack0_empty", 32'(st_empty[0]), 1);
    applyStimulus(2'b01, 1'b1, 8'h00, 0);
    applyStimulus(2'b00, 1'b0, 8'h3C, 0);
    applyStimulus(2'b11, 1'b0, 8'h00, 0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(2'b00, 1'b1, 8'(8'h40 + i), 0);
    applyStimulus(2'b00, 1'b1, 8'hEE, 0);
    applyStimulus(2'b00, 1'b0, 8'h11, 0);
    applyStimulus(2'b11, 1'b0, 8'h00, 5);
    checkOutput("stack1_full", 32'(st_full[1]), 1);

    for (int n = 0; n < 150; n++)
      applyStimulus(2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), $urandom_range(0, 2));

    // Reset while the MOVE push is pending.
    while (ref_stk[1].size() >= DEPTH) applyStimulus(2'b01, 1'b1, 8'h00, 0);
    applyStimulus(2'b00, 1'b0, 8'h5A, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_sel = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("move_pop_before_reset", 32'(pop), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    void'(ref_stk[0].pop_back());
    exp_errs = 0;
    #1 checkResetValues("mid_move_reset");
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_no_strobe", 32'({push, pop}), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_mid_reset", 32'(cmd_ready), 1);
    checkOutput("post_reset_strobe", 32'({push, pop}), 0);
    applyStimulus(2'b10, 1'b1, 8'h00, 0);
    applyStimulus(2'b10, 1'b0, 8'h00, 0);

    // Drain stack 1, then drive enough errors to saturate the counter.
    while (ref_stk[1].size() > 0) applyStimulus(2'b01, 1'b1, 8'h00, 0);
    for (int n = 0; n < 260; n++) applyStimulus(2'b01, 1'b1, 8'h00, 0);
    checkOutput("err_count_saturated", 32'(err_count), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
